led_display_monitor: RTL and testbench
======================================

// Module: led_display_monitor
// PURPOSE
//  Receive side of the four-digit multiplexed 7-segment interface: samples the anode
//  strobes (an3..an0) and segment lines (a..g) and rebuilds the four hex digits shown.
//  Sits in the self-check harness next to the display driver.
//  Reports each complete frame as a 16-bit value with a one-cycle valid pulse.
//  Flags undecodable patterns and loss of scan activity.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples required before a digit is captured (>=2)
//  TIMEOUT_W      20  width of the activity timer; timeout at 2**TIMEOUT_W cycles without a frame
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  an3..an0     in   1   anode strobes, active-low; an3 = leftmost digit (value[15:12])
//  a..g         in   1   segment lines, active-low; seg[6:0] = {a,b,c,d,e,f,g}
//  dp           in   1   decimal point; ignored
//  value        out  16  last complete frame {d3,d2,d1,d0}
//  frame_valid  out  1   one-cycle pulse; value updated in the same cycle
//  decode_err   out  1   one-cycle pulse; stable pattern matched no hex code
//  signal_lost  out  1   level; high while the activity timer is expired
// BEHAVIOUR
//  - Reset: value=0, frame_valid=0, decode_err=0, signal_lost=0.
//    Also clears stable counter, seen mask, digit registers and timer.
//  - All inputs pass through one register stage. Every decision below uses the
//    registered sample s_an/s_seg.
//  - Active digit: s_an must have exactly one bit low (one-hot-low).
//    Zero or multiple bits low = no digit; this resets the stable counter.
//  - Stable counter:
//    - increments while {s_an,s_seg} equals the previous sample;
//    - any change reloads it to 0;
//    - saturates at STABLE_CYCLES-1.
//  - Capture: happens on the cycle the counter first reaches STABLE_CYCLES-1.
//    It fires once per dwell; a new dwell needs an input change.
//  - Decode (active-low seg, hex digits 0..F):
//      0:0000001  1:1001111  2:0010010  3:0000110
//      4:1001100  5:0100100  6:0100000  7:0001111
//      8:0000000  9:0000100  A:0001000  b:1100000
//      C:0110001  d:1000010  E:0110000  F:0111000
//  - Valid capture: writes the nibble into the digit register selected by s_an
//    and sets that bit in the seen mask.
//  - Invalid pattern (including blank 1111111): pulses decode_err in the capture
//    cycle. The digit and mask are unchanged.
//  - Frame complete: when the mask becomes 4'b1111 (in the capture cycle itself),
//    the block does all of the following in the next cycle:
//    - registers value with the new digit included;
//    - pulses frame_valid;
//    - clears the mask;
//    - clears the timer.
//  - Scan order is irrelevant.
//  - Re-capturing a digit already in the mask overwrites it. The most recent
//    capture wins.
//  - Timer:
//    - increments every cycle with no frame;
//    - saturates at all-ones;
//    - signal_lost = timer at all-ones.
//    A frame_valid clears the timer, and signal_lost drops in the following cycle.
//  - Simultaneous frame completion and timer saturation: the frame wins.
//  - Latency: input change to frame_valid = 1 (input reg) + STABLE_CYCLES-1 + 1 cycles
//    for the final digit.
//  - Reset mid-frame discards partial digits; no frame_valid until four fresh captures.
// TESTING
//  - Four-digit scan:
//    - stimulus: drive 1,2,3,4 on an3..an0, 8 cycles each;
//    - required: one frame_valid with value=16'h1234 and no decode_err.
//  - Short dwell:
//    - stimulus: hold a digit 2 cycles with STABLE_CYCLES=4, then move on;
//    - required: no capture, no frame_valid.
//  - Bad pattern:
//    - stimulus: seg=1111111 on an1 for 8 cycles during a scan;
//    - required: one decode_err pulse; frame_valid only after a valid an1 dwell.
//  - Multiple anodes low (an=0011) for 8 cycles:
//    - required: no capture; mask unchanged; scan then resumes normally.
//  - Timeout:
//    - stimulus: TIMEOUT_W=6 and the display is idle;
//    - required: signal_lost high at cycle 63 after reset;
//    - required: it clears one cycle after the next frame_valid.
//  - Mid-frame reset:
//    - stimulus: capture d3,d2, assert reset for 1 cycle, then scan A,B,C,D;
//    - required: value=16'hABCD, with exactly one frame_valid.

Source files
------------

// File: rtl/led_display_monitor.sv
// led_display_monitor
//   Receive side of a four-digit multiplexed 7-segment display. Samples the
//   active-low anode strobes and segment lines, waits for each digit pattern
//   to hold steady, decodes it to a hex nibble and assembles a full frame
//   once every digit position has been seen.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   an3..an0             anode strobes, active-low; an3 = value[15:12]
//   a..g                 segment lines, active-low; seg[6:0] = {a,b,c,d,e,f,g}
//   dp                   decimal point, not used
//   value[15:0]          last complete frame {d3,d2,d1,d0}
//   frame_valid          one-cycle pulse, value changes in the same cycle
//   decode_err           one-cycle pulse, a stable pattern matched no hex digit
//   signal_lost          level, high while the activity timer is saturated
//
// Output contract: frame_valid and decode_err are single-cycle strobes with no
// back-pressure; a consumer must sample value in the cycle frame_valid is high.
module led_display_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT_W     = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        signal_lost
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  // Capture fires on the cycle the counter steps from CNT_MAX-1 to CNT_MAX.
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

  logic [3:0]           s_an_q;
  logic [6:0]           s_seg_q;
  logic [10:0]          prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           mask_q, mask_d;
  logic [15:0]          digits_q, digits_d;
  logic [15:0]          value_q, value_d;
  logic                 fv_q, fv_d;
  logic                 de_q, de_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;

  logic [3:0] an_low;
  logic       one_hot;
  logic       same;
  logic       capture;
  logic [4:0] dec;

  // dp carries no digit information.
  logic unused_dp;
  assign unused_dp = dp;

  // Returns {valid, nibble} for an active-low segment pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'h00;
    case (seg)
      7'b0000001: r = 5'h10;
      7'b1001111: r = 5'h11;
      7'b0010010: r = 5'h12;
      7'b0000110: r = 5'h13;
      7'b1001100: r = 5'h14;
      7'b0100100: r = 5'h15;
      7'b0100000: r = 5'h16;
      7'b0001111: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0000100: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b1100000: r = 5'h1B;
      7'b0110001: r = 5'h1C;
      7'b1000010: r = 5'h1D;
      7'b0110000: r = 5'h1E;
      7'b0111000: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  assign an_low  = ~s_an_q;
  // Exactly one anode driven low: non-zero and a power of two.
  assign one_hot = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
  assign same    = ({s_an_q, s_seg_q} == prev_q);
  assign capture = one_hot && same && (cnt_q == CNT_CAP);
  assign dec     = decode_seg(s_seg_q);

  always_comb begin
    cnt_d    = '0;
    digits_d = digits_q;
    mask_d   = mask_q;
    value_d  = value_q;
    fv_d     = 1'b0;
    de_d     = 1'b0;

    if (one_hot && same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    if (capture) begin
      if (dec[4]) begin
        for (int i = 0; i < 4; i++) begin
          if (an_low[i]) digits_d[i*4 +: 4] = dec[3:0];
        end
        mask_d = mask_q | an_low;
        if (mask_d == 4'hF) begin
          value_d = digits_d;
          fv_d    = 1'b1;
          mask_d  = 4'h0;
        end
      end else begin
        de_d = 1'b1;
      end
    end

    // Cleared the cycle after a frame, so signal_lost drops one cycle late.
    if (fv_q) begin
      timer_d = '0;
    end else if (&timer_q) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_an_q   <= 4'hF;
      s_seg_q  <= 7'h7F;
      prev_q   <= 11'h7FF;
      cnt_q    <= '0;
      mask_q   <= 4'h0;
      digits_q <= 16'h0;
      value_q  <= 16'h0;
      fv_q     <= 1'b0;
      de_q     <= 1'b0;
      timer_q  <= '0;
    end else begin
      s_an_q   <= {an3, an2, an1, an0};
      s_seg_q  <= {a, b, c, d, e, f, g};
      prev_q   <= {s_an_q, s_seg_q};
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      digits_q <= digits_d;
      value_q  <= value_d;
      fv_q     <= fv_d;
      de_q     <= de_d;
      timer_q  <= timer_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = fv_q;
  assign decode_err  = de_q;
  assign signal_lost = &timer_q;

endmodule

// File: tb/tb_led_display_monitor.sv
module tb_led_display_monitor;
  localparam int STABLE = 4;
  localparam int TW     = 6;
  localparam int NEVER  = 32'h7fffffff;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  an_v  = 4'hF;
  logic [6:0]  seg_v = 7'h7F;
  logic        dp_v  = 1'b0;
  logic [15:0] value;
  logic        frame_valid, decode_err, signal_lost;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rst_edge = 0;

  // Active-low patterns for hex digits 0..F, seg = {a,b,c,d,e,f,g}.
  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  led_display_monitor #(.STABLE_CYCLES(STABLE), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset),
    .an3(an_v[3]), .an2(an_v[2]), .an1(an_v[1]), .an0(an_v[0]),
    .a(seg_v[6]), .b(seg_v[5]), .c(seg_v[4]), .d(seg_v[3]),
    .e(seg_v[2]), .f(seg_v[1]), .g(seg_v[0]), .dp(dp_v),
    .value(value), .frame_valid(frame_valid), .decode_err(decode_err),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events, tagged with the edge count at which they appeared.
  logic [47:0] obs_fv_q[$];
  logic [31:0] obs_de_q[$];
  logic        sl_hist[int];

  always @(negedge clk) begin
    if (frame_valid === 1'b1) obs_fv_q.push_back({32'(cyc), value});
    if (decode_err === 1'b1) obs_de_q.push_back(32'(cyc));
    sl_hist[cyc] = signal_lost;
  end

  // Reference model: the input is a sequence of dwells; a dwell on exactly
  // one anode lasting at least STABLE cycles yields one capture whose result
  // shows up STABLE+1 edges after the dwell began.
  logic [47:0] exp_fv_q[$];
  logic [31:0] exp_de_q[$];
  int          run_start = 0;
  logic [3:0]  run_an = 4'hF;
  logic [6:0]  run_seg = 7'h7F;
  logic [15:0] m_digits = 16'h0;
  logic [3:0]  m_mask = 4'h0;

  function automatic int low_pos(input logic [3:0] an);
    int p;
    p = -1;
    if ($countones(~an) == 1) begin
      for (int k = 0; k < 4; k++) if (!an[k]) p = k;
    end
    return p;
  endfunction

  task automatic model_close(input int end_c, input int kill);
    int len, ev, pos, idx;
    len = end_c - run_start;
    ev  = run_start + STABLE + 1;
    pos = low_pos(run_an);
    idx = -1;
    for (int k = 0; k < 16; k++) if (seg_tab[k] == run_seg) idx = k;
    if (pos >= 0 && len >= STABLE && ev < kill) begin
      if (idx < 0) begin
        exp_de_q.push_back(32'(ev));
      end else begin
        m_digits[pos*4 +: 4] = 4'(idx);
        m_mask[pos] = 1'b1;
        if (m_mask == 4'hF) begin
          exp_fv_q.push_back({32'(ev), m_digits});
          m_mask = 4'h0;
        end
      end
    end
  endtask

  // Driver: hold a pattern for len cycles; called #1 after an active edge.
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int len);
    if (an !== run_an || seg !== run_seg) begin
      model_close(cyc, NEVER);
      run_start = cyc;
      run_an    = an;
      run_seg   = seg;
    end
    an_v  = an;
    seg_v = seg;
    dp_v  = 1'($urandom_range(0, 1));
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    model_close(cyc, cyc + 1);
    m_digits = 16'h0;
    m_mask   = 4'h0;
    run_an   = 4'hF;
    run_seg  = 7'h7F;
    reset = 1'b1;
    an_v  = 4'hF;
    seg_v = 7'h7F;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    rst_edge  = cyc;
    run_start = cyc;
  endtask

  task automatic clear_queues();
    exp_fv_q.delete();
    exp_de_q.delete();
    obs_fv_q.delete();
    obs_de_q.delete();
  endtask

  task automatic scan4(input logic [15:0] v, input int len);
    drive(4'b0111, seg_tab[v[15:12]], len);
    drive(4'b1011, seg_tab[v[11:8]], len);
    drive(4'b1101, seg_tab[v[7:4]], len);
    drive(4'b1110, seg_tab[v[3:0]], len);
  endtask

  task automatic test_reset();
    logic [15:0] v;
    apply_reset(3);
    total++; if (value !== 16'h0) begin bad++; $display("FAIL reset_value: got %h want 0000", value); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
    total++; if (decode_err !== 1'b0) begin bad++; $display("FAIL reset_de: got %b want 0", decode_err); end
    total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL reset_sl: got %b want 0", signal_lost); end
    clear_queues();
    v = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
    scan4(v, 8);
    drive(4'hF, 7'h7F, 8);
    total++; if (value !== v) begin bad++; $display("FAIL prereset_value: got %h want %h", value, v); end
    apply_reset(1);
    total++; if (value !== 16'h0) begin bad++; $display("FAIL rereset_value: got %h want 0000", value); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rereset_fv: got %b want 0", frame_valid); end
    total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL rereset_sl: got %b want 0", signal_lost); end
  endtask

  task automatic test_four_digit_scan();
    logic [15:0] got;
    apply_reset(1);
    clear_queues();
    scan4(16'h1234, 8);
    drive(4'hF, 7'h7F, 10);
    got = (obs_fv_q.size() == 0) ? 16'hxxxx : obs_fv_q[0][15:0];
    total++; if (obs_fv_q.size() != 1 || got !== 16'h1234) begin bad++; $display("FAIL scan_value: got n=%0d val=%h want n=1 val=1234", obs_fv_q.size(), got); end
    total++; if (obs_de_q.size() != 0) begin bad++; $display("FAIL scan_de: got %0d pulses want 0", obs_de_q.size()); end
    total++; if (obs_fv_q.size() != exp_fv_q.size()) begin bad++; $display("FAIL scan_fv_count: got %0d want %0d", obs_fv_q.size(), exp_fv_q.size()); end
    for (int i = 0; i < exp_fv_q.size() && i < obs_fv_q.size(); i++) begin
      total++;
      if (obs_fv_q[i] !== exp_fv_q[i]) begin
        bad++;
        $display("FAIL scan_frame[%0d]: got cyc=%0d val=%h want cyc=%0d val=%h", i, obs_fv_q[i][47:16], obs_fv_q[i][15:0], exp_fv_q[i][47:16], exp_fv_q[i][15:0]);
      end
    end
  endtask

  task automatic test_short_dwell();
    logic [15:0] v;
    logic [15:0] got;
    apply_reset(1);
    clear_queues();
    v = 16'($urandom_range(0, 65535));
    scan4(v, 2);
    scan4(v ^ 16'h1111, STABLE - 1);
    drive(4'hF, 7'h7F, 8);
    total++; if (obs_fv_q.size() != 0) begin bad++; $display("FAIL short_fv: got %0d frames want 0", obs_fv_q.size()); end
    total++; if (obs_de_q.size() != 0) begin bad++; $display("FAIL short_de: got %0d pulses want 0", obs_de_q.size()); end
    scan4(v, STABLE);
    drive(4'hF, 7'h7F, 8);
    got = (obs_fv_q.size() == 0) ? 16'hxxxx : obs_fv_q[0][15:0];
    total++; if (obs_fv_q.size() != 1 || got !== v) begin bad++; $display("FAIL short_boundary: got n=%0d val=%h want n=1 val=%h", obs_fv_q.size(), got, v); end
    total++; if (obs_fv_q.size() != exp_fv_q.size()) begin bad++; $display("FAIL short_fv_count: got %0d want %0d", obs_fv_q.size(), exp_fv_q.size()); end
    for (int i = 0; i < exp_fv_q.size() && i < obs_fv_q.size(); i++) begin
      total++;
      if (obs_fv_q[i] !== exp_fv_q[i]) begin
        bad++;
        $display("FAIL short_frame[%0d]: got cyc=%0d val=%h want cyc=%0d val=%h", i, obs_fv_q[i][47:16], obs_fv_q[i][15:0], exp_fv_q[i][47:16], exp_fv_q[i][15:0]);
      end
    end
  endtask

  task automatic test_bad_pattern();
    logic [15:0] v;
    int fcyc, dcyc;
    apply_reset(1);
    clear_queues();
    v = 16'($urandom_range(0, 65535));
    drive(4'b0111, seg_tab[v[15:12]], 8);
    drive(4'b1011, seg_tab[v[11:8]], 8);
    drive(4'b1101, 7'h7F, 8);
    drive(4'b1110, seg_tab[v[3:0]], 8);
    drive(4'hF, 7'h7F, 6);
    total++; if (obs_de_q.size() != 1) begin bad++; $display("FAIL bad_de_count: got %0d want 1", obs_de_q.size()); end
    total++; if (obs_fv_q.size() != 0) begin bad++; $display("FAIL bad_early_fv: got %0d want 0", obs_fv_q.size()); end
    drive(4'b1101, seg_tab[v[7:4]], 8);
    drive(4'hF, 7'h7F, 8);
    total++; if (obs_fv_q.size() != exp_fv_q.size()) begin bad++; $display("FAIL bad_fv_count: got %0d want %0d", obs_fv_q.size(), exp_fv_q.size()); end
    for (int i = 0; i < exp_fv_q.size() && i < obs_fv_q.size(); i++) begin
      total++;
      if (obs_fv_q[i] !== exp_fv_q[i]) begin
        bad++;
        $display("FAIL bad_frame[%0d]: got cyc=%0d val=%h want cyc=%0d val=%h", i, obs_fv_q[i][47:16], obs_fv_q[i][15:0], exp_fv_q[i][47:16], exp_fv_q[i][15:0]);
      end
    end
    for (int i = 0; i < exp_de_q.size() && i < obs_de_q.size(); i++) begin
      total++;
      if (obs_de_q[i] !== exp_de_q[i]) begin bad++; $display("FAIL bad_de[%0d]: got cyc=%0d want cyc=%0d", i, obs_de_q[i], exp_de_q[i]); end
    end
    if (obs_fv_q.size() > 0 && obs_de_q.size() > 0) begin
      fcyc = int'(obs_fv_q[0][47:16]);
      dcyc = int'(obs_de_q[0]);
      total++; if (fcyc <= dcyc) begin bad++; $display("FAIL bad_order: got frame cyc=%0d want after de cyc=%0d", fcyc, dcyc); end
    end
  endtask

  task automatic test_multi_anode();
    logic [15:0] v;
    logic [15:0] got;
    apply_reset(1);
    clear_queues();
    v = 16'($urandom_range(0, 65535));
    drive(4'b0111, seg_tab[v[15:12]], 8);
    drive(4'b1011, seg_tab[v[11:8]], 8);
    drive(4'b0011, seg_tab[4'(~v[7:4])], 8);
    drive(4'b0000, seg_tab[4'(~v[3:0])], 8);
    drive(4'b1101, seg_tab[v[7:4]], 8);
    drive(4'b1110, seg_tab[v[3:0]], 8);
    drive(4'hF, 7'h7F, 8);
    got = (obs_fv_q.size() == 0) ? 16'hxxxx : obs_fv_q[0][15:0];
    total++; if (obs_fv_q.size() != 1 || got !== v) begin bad++; $display("FAIL multi_value: got n=%0d val=%h want n=1 val=%h", obs_fv_q.size(), got, v); end
    total++; if (obs_fv_q.size() != exp_fv_q.size()) begin bad++; $display("FAIL multi_fv_count: got %0d want %0d", obs_fv_q.size(), exp_fv_q.size()); end
    for (int i = 0; i < exp_fv_q.size() && i < obs_fv_q.size(); i++) begin
      total++;
      if (obs_fv_q[i] !== exp_fv_q[i]) begin
        bad++;
        $display("FAIL multi_frame[%0d]: got cyc=%0d val=%h want cyc=%0d val=%h", i, obs_fv_q[i][47:16], obs_fv_q[i][15:0], exp_fv_q[i][47:16], exp_fv_q[i][15:0]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] v;
    int fcyc;
    apply_reset(1);
    clear_queues();
    drive(4'hF, 7'h7F, 70);
    total++; if (sl_hist[rst_edge + 62] !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", sl_hist[rst_edge + 62]); end
    total++; if (sl_hist[rst_edge + 63] !== 1'b1) begin bad++; $display("FAIL timeout_at_63: got %b want 1", sl_hist[rst_edge + 63]); end
    v = 16'($urandom_range(0, 65535));
    scan4(v, 8);
    drive(4'hF, 7'h7F, 8);
    total++; if (obs_fv_q.size() != exp_fv_q.size()) begin bad++; $display("FAIL timeout_fv_count: got %0d want %0d", obs_fv_q.size(), exp_fv_q.size()); end
    if (obs_fv_q.size() > 0 && exp_fv_q.size() > 0) begin
      total++;
      if (obs_fv_q[0] !== exp_fv_q[0]) begin
        bad++;
        $display("FAIL timeout_frame: got cyc=%0d val=%h want cyc=%0d val=%h", obs_fv_q[0][47:16], obs_fv_q[0][15:0], exp_fv_q[0][47:16], exp_fv_q[0][15:0]);
      end
      fcyc = int'(obs_fv_q[0][47:16]);
      total++; if (sl_hist[fcyc] !== 1'b1) begin bad++; $display("FAIL timeout_at_frame: got %b want 1", sl_hist[fcyc]); end
      total++; if (sl_hist[fcyc + 1] !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", sl_hist[fcyc + 1]); end
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [15:0] got;
    apply_reset(1);
    clear_queues();
    drive(4'b0111, seg_tab[$urandom_range(0, 15)], 8);
    drive(4'b1011, seg_tab[$urandom_range(0, 15)], 8);
    apply_reset(1);
    scan4(16'hABCD, 8);
    drive(4'hF, 7'h7F, 8);
    got = (obs_fv_q.size() == 0) ? 16'hxxxx : obs_fv_q[0][15:0];
    total++; if (obs_fv_q.size() != 1 || got !== 16'hABCD) begin bad++; $display("FAIL midreset_value: got n=%0d val=%h want n=1 val=abcd", obs_fv_q.size(), got); end
    total++; if (obs_fv_q.size() != exp_fv_q.size()) begin bad++; $display("FAIL midreset_fv_count: got %0d want %0d", obs_fv_q.size(), exp_fv_q.size()); end
    for (int i = 0; i < exp_fv_q.size() && i < obs_fv_q.size(); i++) begin
      total++;
      if (obs_fv_q[i] !== exp_fv_q[i]) begin
        bad++;
        $display("FAIL midreset_frame[%0d]: got cyc=%0d val=%h want cyc=%0d val=%h", i, obs_fv_q[i][47:16], obs_fv_q[i][15:0], exp_fv_q[i][47:16], exp_fv_q[i][15:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] an;
    logic [6:0] seg;
    apply_reset(1);
    clear_queues();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 8) an = ~(4'b0001 << $urandom_range(0, 3));
      else an = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 9) seg = seg_tab[$urandom_range(0, 15)];
      else seg = 7'($urandom_range(0, 127));
      drive(an, seg, $urandom_range(1, 9));
    end
    drive(4'hF, 7'h7F, 10);
    total++; if (obs_fv_q.size() != exp_fv_q.size()) begin bad++; $display("FAIL rand_fv_count: got %0d want %0d", obs_fv_q.size(), exp_fv_q.size()); end
    total++; if (obs_de_q.size() != exp_de_q.size()) begin bad++; $display("FAIL rand_de_count: got %0d want %0d", obs_de_q.size(), exp_de_q.size()); end
    for (int i = 0; i < exp_fv_q.size() && i < obs_fv_q.size(); i++) begin
      total++;
      if (obs_fv_q[i] !== exp_fv_q[i]) begin
        bad++;
        $display("FAIL rand_frame[%0d]: got cyc=%0d val=%h want cyc=%0d val=%h", i, obs_fv_q[i][47:16], obs_fv_q[i][15:0], exp_fv_q[i][47:16], exp_fv_q[i][15:0]);
      end
    end
    for (int i = 0; i < exp_de_q.size() && i < obs_de_q.size(); i++) begin
      total++;
      if (obs_de_q[i] !== exp_de_q[i]) begin bad++; $display("FAIL rand_de[%0d]: got cyc=%0d want cyc=%0d", i, obs_de_q[i], exp_de_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_four_digit_scan();
    test_short_dwell();
    test_bad_pattern();
    test_multi_anode();
    test_timeout();
    test_mid_frame_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
